// File: rtl/xbus_router_if.sv
// Master-side request/response bus plus the slave-side select/data fan-out of
// the address-decoding router.
interface xbus_router_if #(
  parameter int NSLAVES = 4
);
  logic                   m_as;
  logic [31:0]            m_addr;
  logic                   m_we;
  logic [31:0]            m_wdata;
  logic                   m_ack;
  logic                   m_err;
  logic [31:0]            m_rdata;
  logic [NSLAVES-1:0]     s_cs;
  logic [31:0]            s_addr;
  logic                   s_we;
  logic [31:0]            s_wdata;
  logic [NSLAVES*32-1:0]  s_rdata;
  logic [NSLAVES-1:0]     s_ack;

  // The router sits on the slave side of the master bus.
  modport slave (
    input  m_as, m_addr, m_we, m_wdata, s_rdata, s_ack,
    output m_ack, m_err, m_rdata, s_cs, s_addr, s_we, s_wdata
  );

  modport master (
    output m_as, m_addr, m_we, m_wdata, s_rdata, s_ack,
    input  m_ack, m_err, m_rdata, s_cs, s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/xbus_router.sv
// Single-master address router: decodes a request onto one of NSLAVES ports,
// waits for that slave's acknowledge with a timeout and returns a one-cycle response.
module xbus_router #(
  parameter int                      NSLAVES  = 4,
  parameter logic [32*NSLAVES-1:0]   SLV_BASE = {32'h1000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0000_1000},
  parameter logic [32*NSLAVES-1:0]   SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_FF00},
  parameter int                      TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  xbus_router_if.slave bus,
  output logic [31:0] err_addr,
  output logic [7:0]  err_cnt
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [IW-1:0]      r_sel;
  logic [NSLAVES-1:0] r_cs;
  logic [CW-1:0]      r_wait;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_err_addr;
  logic [7:0]         r_err_cnt;

  logic               w_hit;
  logic [IW-1:0]      w_hit_idx;
  logic               w_sel_ack;
  logic [31:0]        w_sel_rdata;
  logic               w_tmo;
  logic               w_accept_hit;
  logic               w_accept_miss;
  logic               w_done_ok;
  logic               w_done_tmo;

  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  assign w_sel_ack   = bus.s_ack[r_sel];
  assign w_sel_rdata = bus.s_rdata[32*r_sel +: 32];
  assign w_tmo       = (r_wait == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept_hit  = 1'b0;
    w_accept_miss = 1'b0;
    w_done_ok     = 1'b0;
    w_done_tmo    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m_as) begin
          if (w_hit) begin
            w_next       = ACCESS;
            w_accept_hit = 1'b1;
          end else begin
            w_next        = RESP;
            w_accept_miss = 1'b1;
          end
        end
      end
      ACCESS: begin
        // An acknowledge in the timeout cycle still completes without error.
        if (w_sel_ack) begin
          w_next    = RESP;
          w_done_ok = 1'b1;
        end else if (w_tmo) begin
          w_next     = RESP;
          w_done_tmo = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_cs       <= '0;
      r_wait     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_accept_hit) begin
        r_addr  <= bus.m_addr;
        r_we    <= bus.m_we;
        r_wdata <= bus.m_wdata;
        r_sel   <= w_hit_idx;
        r_cs    <= NSLAVES'(1) << w_hit_idx;
        r_wait  <= '0;
      end else if (r_state == ACCESS) begin
        r_wait <= r_wait + CW'(1);
        if (w_done_ok || w_done_tmo) r_cs <= '0;
      end

      if (w_done_ok) begin
        r_err   <= 1'b0;
        r_rdata <= w_sel_rdata;
      end else if (w_accept_miss || w_done_tmo) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end

      // A miss never latched the request, so its address comes from the live bus.
      if (w_accept_miss || w_done_tmo) begin
        r_err_addr <= w_accept_miss ? bus.m_addr : r_addr;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.m_ack   = (r_state == RESP);
  assign bus.m_err   = (r_state == RESP) && r_err;
  assign bus.m_rdata = r_rdata;
  assign bus.s_cs    = r_cs;
  assign bus.s_addr  = r_addr;
  assign bus.s_we    = r_we;
  assign bus.s_wdata = r_wdata;
  assign err_addr    = r_err_addr;
  assign err_cnt     = r_err_cnt;

endmodule

// File: doc/xbus_router.md
XBUS_ROUTER -- requirements
Module: xbus_router

Interface
REQ-001 Parameter NSLAVES, default 4: number of slave ports (1..16).
REQ-002 Parameter SLV_BASE, default {32'h1000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0000_1000}: packed slave base addresses; slave i occupies bits [32*i+31:32*i].
REQ-003 Parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_FF00}: packed match masks, same packing as SLV_BASE.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles spent waiting for a slave acknowledge (1..65535).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 m_as  input  1  master request strobe; the master holds it and m_addr/m_we/m_wdata stable until m_ack.
REQ-008 m_addr  input  32  master address.
REQ-009 m_we  input  1  master write enable.
REQ-010 m_wdata  input  32  master write data.
REQ-011 m_ack  output  1  one-cycle transaction-complete pulse.
REQ-012 m_err  output  1  one-cycle error flag, asserted only together with m_ack.
REQ-013 m_rdata  output  32  read data, valid while m_ack=1 and held until the next response.
REQ-014 s_cs  output  NSLAVES  one-hot slave select.
REQ-015 s_addr, s_we, s_wdata  output  32/1/32  registered copies of the accepted request.
REQ-016 s_rdata  input  NSLAVES*32  packed slave read data.
REQ-017 s_ack  input  NSLAVES  per-slave acknowledge.
REQ-018 err_addr  output  32  address of the most recent errored transaction.
REQ-019 err_cnt  output  8  saturating error count.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-021 Decode: slave i hits when (m_addr & mask_i) == base_i; on overlapping hits the lowest index SHALL win.
REQ-022 IDLE with m_as=1 and a hit SHALL latch addr/we/wdata and the hit index, and SHALL move to ACCESS with s_cs set to the one-hot value of that index in the next cycle.
REQ-023 IDLE with m_as=1 and no hit SHALL move to RESP with the error flag set; s_cs SHALL stay 0.
REQ-024 ACCESS SHALL hold s_cs, s_addr, s_we and s_wdata stable and SHALL increment the wait counter each cycle.
REQ-025 ACCESS with s_ack[sel]=1 SHALL capture s_rdata[sel] into m_rdata, clear s_cs, and move to RESP with no error.
REQ-026 Acknowledges from non-selected slaves SHALL be ignored.
REQ-027 ACCESS with the wait counter equal to TIMEOUT-1 and no s_ack[sel] SHALL clear s_cs, set m_rdata=0 and move to RESP with the error flag set.
REQ-028 When s_ack[sel] arrives in the timeout cycle, the acknowledge SHALL win and no error is raised.
REQ-029 RESP SHALL assert m_ack for exactly one cycle, with m_err equal to the error flag, then return to IDLE.
REQ-030 m_as SHALL be sampled only in IDLE; the master deasserts it in the m_ack cycle to avoid reissue.
REQ-031 Latency: hit with immediate slave acknowledge gives m_ack 2 cycles after acceptance; decode miss gives m_ack 1 cycle after acceptance; timeout gives m_ack TIMEOUT+1 cycles after acceptance.
REQ-032 On an errored response, m_rdata SHALL be 32'h0.
REQ-033 Each error SHALL load err_addr with the latched address and increment err_cnt, saturating at 8'hFF.
REQ-034 The wait counter SHALL be cleared on entry to ACCESS and SHALL have width clog2(TIMEOUT+1).

Reset
REQ-035 While rst=1: state=IDLE; m_ack, m_err, s_cs, s_we, err_cnt and the wait counter = 0; m_rdata, s_addr, s_wdata and err_addr = 32'h0.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transaction with no m_ack pulse; s_cs SHALL be 0 in the cycle after the reset edge.

Verification
REQ-037 Read 0x8000_0010 with slave1 acknowledging in its first ACCESS cycle with data 0xDEADBEEF -> s_cs=4'b0010 for 1 cycle; m_ack=1, m_err=0, m_rdata=0xDEADBEEF two cycles after acceptance.
REQ-038 Write 0x0001_0000 data 0x5A, with slave2 acknowledging after 3 cycles -> s_cs=4'b0100 for 3 cycles with s_we=1 and s_wdata=0x5A; then m_ack with m_err=0.
REQ-039 Access to 0x2000_0000 (no hit) -> m_ack=m_err=1 one cycle after acceptance; s_cs never set; err_addr=0x2000_0000; err_cnt=1.
REQ-040 TIMEOUT=4, slave0 silent at 0x0000_1004 -> s_cs=4'b0001 for 4 cycles; m_ack=m_err=1 with m_rdata=0; acknowledge arriving in the 4th cycle instead -> m_err=0.
REQ-041 slave3 asserts s_ack during a slave1 access -> ignored; 300 consecutive decode misses -> err_cnt=8'hFF.
REQ-042 rst asserted in the 2nd ACCESS cycle -> no m_ack; all outputs at reset values; a new request afterwards completes normally.
